// File: rtl/mc_controller.sv
// Multi-cycle controller for the accumulator CPU: fetch, decode, operand
// access and execute, with memory wait states, a wait-state watchdog,
// illegal-opcode trapping and a resumable HALT.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IF_ADDR   | present PC to memory, all strobes idle
// IF_MEM    | instruction read, wait for mem_ready
// DECODE    | load IR, bump PC, latch opcode into ir_op
// OP_MEM    | operand read (or store write for STO), wait for mem_ready
// EXEC      | one-cycle ALU / load / jump / skip
// HALT      | stopped; resume restarts unless an error flag is latched
module mc_controller #(
  parameter int OPCODE_W     = 3,
  parameter int ALU_OP_W     = 2,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                irLoad,
  output logic                pcInc,
  output logic                memRead,
  output logic                memWrite,
  output logic                ACCwrite,
  output logic                ALUToACC,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                jump,
  output logic                skip,
  output logic                Halt,
  output logic                bus_err,
  output logic                illegal
);

  localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    S_IF_ADDR, S_IF_MEM, S_DECODE, S_OP_MEM, S_EXEC, S_HALT
  } state_t;

  state_t           state, state_n;
  logic [2:0]       ir_op;
  logic [CNT_W-1:0] wait_cnt;
  logic             op_illegal;
  logic             wd_expire;
  logic             set_bus_err;
  logic             set_illegal;
  logic             waiting;
  logic             entering_wait;

  // Any set bit above the 3-bit base opcode marks the instruction illegal.
  generate
    if (OPCODE_W > 3) begin : g_wide_op
      assign op_illegal = |opcode[OPCODE_W-1:3];
    end else begin : g_narrow_op
      assign op_illegal = 1'b0;
    end
  endgenerate

  // A timeout of zero disables the watchdog entirely.
  assign wd_expire = (WAIT_TIMEOUT != 0) && (wait_cnt == CNT_W'(WAIT_TIMEOUT)) && !mem_ready;

  assign waiting       = (state == S_IF_MEM) || (state == S_OP_MEM);
  assign entering_wait = !waiting && ((state_n == S_IF_MEM) || (state_n == S_OP_MEM));

  // State register, latched opcode, wait counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IF_ADDR;
      ir_op    <= '0;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) ir_op <= opcode[2:0];
      if (set_bus_err) bus_err <= 1'b1;
      if (set_illegal) illegal <= 1'b1;
      if (entering_wait) wait_cnt <= '0;
      else if (waiting && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Next-state logic and Moore outputs; skip alone follows zero in EXEC.
  always_comb begin
    state_n     = state;
    set_bus_err = 1'b0;
    set_illegal = 1'b0;
    irLoad      = 1'b0;
    pcInc       = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    ACCwrite    = 1'b0;
    ALUToACC    = 1'b0;
    ALU_OP      = '0;
    jump        = 1'b0;
    skip        = 1'b0;
    Halt        = 1'b0;
    case (state)
      S_IF_ADDR: state_n = S_IF_MEM;
      S_IF_MEM: begin
        memRead = 1'b1;
        if (mem_ready) state_n = S_DECODE;
        else if (wd_expire) begin
          state_n     = S_HALT;
          set_bus_err = 1'b1;
        end
      end
      S_DECODE: begin
        irLoad = 1'b1;
        pcInc  = 1'b1;
        if (op_illegal) begin
          state_n     = S_HALT;
          set_illegal = 1'b1;
        end else begin
          case (opcode[2:0])
            OP_HLT:         state_n = S_HALT;
            OP_SKZ, OP_JMP: state_n = S_EXEC;
            default:        state_n = S_OP_MEM;
          endcase
        end
      end
      S_OP_MEM: begin
        if (ir_op == OP_STO) memWrite = 1'b1;
        else                 memRead  = 1'b1;
        if (mem_ready) state_n = (ir_op == OP_STO) ? S_IF_ADDR : S_EXEC;
        else if (wd_expire) begin
          state_n     = S_HALT;
          set_bus_err = 1'b1;
        end
      end
      S_EXEC: begin
        state_n = S_IF_ADDR;
        case (ir_op)
          OP_ADD: begin
            ACCwrite = 1'b1;
            ALUToACC = 1'b1;
          end
          OP_AND: begin
            ACCwrite    = 1'b1;
            ALUToACC    = 1'b1;
            ALU_OP[1:0] = 2'b01;
          end
          OP_XOR: begin
            ACCwrite    = 1'b1;
            ALUToACC    = 1'b1;
            ALU_OP[1:0] = 2'b10;
          end
          OP_LDA:  ACCwrite = 1'b1;
          OP_JMP:  jump     = 1'b1;
          OP_SKZ:  skip     = zero;
          default: ;
        endcase
      end
      S_HALT: begin
        Halt = 1'b1;
        if (resume && !bus_err && !illegal) state_n = S_IF_ADDR;
      end
      default: state_n = S_IF_ADDR;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: an instruction-level model turns each issued
// instruction (opcode, zero flag, fetch/operand wait counts) into the list
// of per-cycle output vectors it must produce; a negedge monitor pops and
// compares them against the DUT.
module tb_mc_controller;
  localparam int OW = 4;
  localparam int AW = 3;
  localparam int WT = 15;

  localparam logic [13:0] IRL = 14'h2000;
  localparam logic [13:0] PCI = 14'h1000;
  localparam logic [13:0] MRD = 14'h0800;
  localparam logic [13:0] MWR = 14'h0400;
  localparam logic [13:0] ACW = 14'h0200;
  localparam logic [13:0] A2A = 14'h0100;
  localparam logic [13:0] AL1 = 14'h0020;
  localparam logic [13:0] AL2 = 14'h0040;
  localparam logic [13:0] JMP = 14'h0010;
  localparam logic [13:0] SKP = 14'h0008;
  localparam logic [13:0] HLT = 14'h0004;
  localparam logic [13:0] BER = 14'h0002;
  localparam logic [13:0] ILL = 14'h0001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [OW-1:0] opcode = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          resume = 1'b0;
  logic          irLoad, pcInc, memRead, memWrite, ACCwrite, ALUToACC;
  logic [AW-1:0] ALU_OP;
  logic          jump, skip, Halt, bus_err, illegal;

  mc_controller #(.OPCODE_W(OW), .ALU_OP_W(AW), .WAIT_TIMEOUT(WT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .irLoad(irLoad), .pcInc(pcInc), .memRead(memRead),
    .memWrite(memWrite), .ACCwrite(ACCwrite), .ALUToACC(ALUToACC),
    .ALU_OP(ALU_OP), .jump(jump), .skip(skip), .Halt(Halt),
    .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [13:0] exp;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  logic [13:0] act;
  assign act = {irLoad, pcInc, memRead, memWrite, ACCwrite, ALUToACC, ALU_OP,
                jump, skip, Halt, bus_err, illegal};

  // Monitor: one expected vector per cycle, plus the exclusivity rules.
  always @(negedge clk) begin
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        tests++;
        if (act !== e.exp) begin
          fails++;
          $display("FAIL outputs cycle %0d: got %h expected %h", cyc, act, e.exp);
        end
      end
      tests++;
      if ((memRead && memWrite) || (jump && ACCwrite)) begin
        fails++;
        $display("FAIL exclusive cycle %0d: got %h expected no memRead&memWrite or jump&ACCwrite", cyc, act);
      end
    end
  end

  // Drive one cycle of inputs (negative argument = random) and post its expectation.
  task automatic step(input bit r, input int mr, input int res, input int op,
                      input int z, input logic [13:0] ex, input bit chk);
    exp_t t;
    rst       = r;
    mem_ready = (mr < 0) ? 1'($urandom_range(0, 1)) : 1'(mr);
    resume    = (res < 0) ? 1'($urandom_range(0, 1)) : 1'(res);
    opcode    = (op < 0) ? OW'($urandom) : OW'(op);
    zero      = (z < 0) ? 1'($urandom_range(0, 1)) : 1'(z);
    t.chk = chk;
    t.exp = ex;
    q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: what each instruction shows cycle by cycle.
  task automatic run_instr(input int op, input int z, input int wf, input int wo);
    logic [13:0] om;
    logic [13:0] ex;
    step(0, -1, -1, -1, -1, '0, 1);
    repeat (wf) step(0, 0, -1, -1, -1, MRD, 1);
    step(0, 1, -1, -1, -1, MRD, 1);
    step(0, -1, -1, op, -1, IRL | PCI, 1);
    if (op > 7) begin
      repeat (2) step(0, -1, 1, -1, -1, HLT | ILL, 1);
      step(1, -1, 1, -1, -1, HLT | ILL, 1);
    end else if (op == 0) begin
      repeat ($urandom_range(0, 3)) step(0, -1, 0, -1, -1, HLT, 1);
      step(0, -1, 1, -1, -1, HLT, 1);
    end else if (op == 1) begin
      step(0, -1, -1, -1, z, (z != 0) ? SKP : 14'h0, 1);
    end else if (op == 7) begin
      step(0, -1, -1, -1, -1, JMP, 1);
    end else begin
      om = (op == 6) ? MWR : MRD;
      repeat (wo) step(0, 0, -1, -1, -1, om, 1);
      step(0, 1, -1, -1, -1, om, 1);
      if (op != 6) begin
        case (op)
          2:       ex = ACW | A2A;
          3:       ex = ACW | A2A | AL1;
          4:       ex = ACW | A2A | AL2;
          default: ex = ACW;
        endcase
        step(0, -1, -1, -1, -1, ex, 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int op;
    repeat (2) @(posedge clk);
    #1;
    // Directed: plain ALU loops, SKZ both ways, JMP, STO with wait states.
    run_instr(2, 0, 0, 0);
    run_instr(2, 1, 0, 0);
    run_instr(1, 1, 0, 0);
    run_instr(1, 0, 0, 0);
    run_instr(7, 0, 0, 0);
    run_instr(6, 0, 0, 3);
    run_instr(0, 0, 0, 0);
    run_instr(3, 0, 1, 2);
    run_instr(4, 0, 2, 0);
    run_instr(5, 0, 0, 1);
    // mem_ready on the terminal-count cycle wins over the watchdog.
    run_instr(5, 0, WT, WT);
    run_instr(6, 0, WT, WT);
    // Illegal opcode: sticky flag, resume ignored, cleared by rst.
    run_instr(10, 0, 0, 0);
    run_instr(2, 0, 0, 0);
    // Fetch timeout: 16 cycles of memRead then HALT with bus_err.
    step(0, -1, -1, -1, -1, '0, 1);
    repeat (WT + 1) step(0, 0, -1, -1, -1, MRD, 1);
    repeat (3) step(0, -1, 1, -1, -1, HLT | BER, 1);
    step(1, -1, 1, -1, -1, HLT | BER, 1);
    // Operand timeout.
    step(0, -1, -1, -1, -1, '0, 1);
    step(0, 1, -1, -1, -1, MRD, 1);
    step(0, -1, -1, 2, -1, IRL | PCI, 1);
    repeat (WT + 1) step(0, 0, -1, -1, -1, MRD, 1);
    step(0, -1, 1, -1, -1, HLT | BER, 1);
    step(1, -1, 1, -1, -1, HLT | BER, 1);
    // Reset in the middle of an operand wait.
    step(0, -1, -1, -1, -1, '0, 1);
    step(0, 1, -1, -1, -1, MRD, 1);
    step(0, -1, -1, 6, -1, IRL | PCI, 1);
    step(1, 0, -1, -1, -1, MWR, 1);
    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) op = 8 + $urandom_range(0, 7);
      else op = $urandom_range(0, 7);
      run_instr(op, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_instr(2, 0, 0, 0);
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Parametrised multi-cycle successor to the 8-bit RISC CPU controller. It sequences fetch, decode, operand access and execute through an explicit FSM, and handshakes with memory through a mem_ready wait-state input. It adds a watchdog timeout, detection of illegal opcodes when the opcode is widened, and a HALT state that can be resumed. It sits between the instruction register/PC/accumulator datapath and the unified instruction/data memory.

Parameters:
OPCODE_W, 3, opcode width (>=3); any nonzero bit above [2:0] marks the opcode illegal
ALU_OP_W, 2, ALU_OP width (>=2); bits above [1:0] are always 0
WAIT_TIMEOUT, 15, max cycles a memory state may wait for mem_ready before a bus error; 0 disables the watchdog

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  OPCODE_W  opcode field from memory data; sampled in DECODE
zero  in  1  accumulator==0 flag
mem_ready  in  1  memory completes the current read/write this cycle
resume  in  1  leaves HALT (only when no error is latched)
irLoad  out  1  load instruction register
pcInc  out  1  increment PC
memRead  out  1  memory read request
memWrite  out  1  memory write request
ACCwrite  out  1  write accumulator
ALUToACC  out  1  1: ACC<-ALU result, 0: ACC<-memory data
ALU_OP  out  ALU_OP_W  00 ADD, 01 AND, 10 XOR; 00 whenever not in EXEC
jump  out  1  load PC from the operand field
skip  out  1  extra PC increment
Halt  out  1  controller halted
bus_err  out  1  sticky: memory watchdog expired
illegal  out  1  sticky: illegal opcode decoded

Behaviour:
- Opcode map (bits [2:0]): 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- Moore outputs decoded from state and the latched opcode ir_op. No output depends combinationally on opcode, zero or mem_ready, except skip in EXEC, which is combinational on zero.
- Reset: state=IF_ADDR, ir_op=0, wait counter=0, bus_err=0, illegal=0. Every output is 0. rst overrides any state, including mid-wait and HALT.
- IF_ADDR: all outputs 0. Next state IF_MEM.
- IF_MEM: memRead=1. If mem_ready, go to DECODE. Otherwise stay and increment the wait counter.
- DECODE: irLoad=1, pcInc=1, ir_op<=opcode.
  - Illegal opcode goes to HALT and sets illegal.
  - HLT goes to HALT.
  - SKZ and JMP go to EXEC.
  - ADD, AND, XOR, LDA and STO go to OP_MEM.
- OP_MEM: memWrite=1 if ir_op==STO, otherwise memRead=1. Wait for mem_ready.
  - On mem_ready, STO goes to IF_ADDR; every other opcode goes to EXEC.
- EXEC: lasts one cycle, then goes to IF_ADDR.
  - ADD/AND/XOR: ACCwrite=1, ALUToACC=1, ALU_OP=00/01/10.
  - LDA: ACCwrite=1, ALUToACC=0.
  - JMP: jump=1.
  - SKZ: skip=zero.
- HALT: Halt=1, all other strobes 0.
  - resume=1 with bus_err=0 and illegal=0 goes to IF_ADDR.
  - resume is ignored while either error flag is set; only rst clears the flags.
- Watchdog: the counter clears on entry to IF_MEM and OP_MEM and increments each cycle the state waits with mem_ready=0.
  - If the counter reaches WAIT_TIMEOUT with mem_ready=0, next state is HALT and bus_err<=1.
  - mem_ready arriving in that same cycle wins: normal transition, no error.
- Latency with mem_ready tied high:
  - ADD/AND/XOR/LDA: 5 cycles.
  - STO, JMP, SKZ: 4 cycles.
  - HLT reaches HALT 3 cycles after IF_ADDR.
  - Each low mem_ready cycle adds 1 cycle.
- memRead and memWrite are never both 1. At most one of jump and ACCwrite is 1 in any cycle.

Test Plan:
- Reset then run with mem_ready=1 and opcode=3'b010 (ADD): states IF_ADDR, IF_MEM, DECODE, OP_MEM, EXEC repeat. ACCwrite=ALUToACC=1 and ALU_OP=00 exactly one cycle out of every 5. Halt=0 throughout.
- opcode=3'b001 (SKZ): with zero=1, skip=1 in EXEC, period 4 cycles. With zero=0, skip stays 0. opcode=3'b111 (JMP): jump=1 once per 4 cycles.
- STO with mem_ready held low for 3 cycles in OP_MEM: memWrite=1 for 4 consecutive cycles, EXEC is never entered, and the next IF_ADDR follows immediately.
- opcode=3'b000: Halt=1 from the 3rd cycle onward. A resume pulse returns to IF_ADDR next cycle, with memRead=1 the cycle after.
- WAIT_TIMEOUT=15 and mem_ready=0 forever: memRead=1 for 16 cycles, then HALT with bus_err=1. resume has no effect. rst clears everything to 0.
- OPCODE_W=4, opcode=4'b1010: illegal=1 and Halt=1 after DECODE. Also: asserting rst mid-OP_MEM returns all outputs to 0 on the next edge.
